// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a pending-write scoreboard.
//
// Two combinational read ports, one writeback port and one reservation port.
// Each register r >= 1 has a pending-write counter: issue bumps it when it
// reserves r as a destination, writeback drops it when the result lands.
// A read of a register with a non-zero counter returns the stale array value
// with its ready flag low, so the consumer stalls.
// Register 0 reads as zero, ignores writes, and never holds a reservation.
//
// Optional feature (macro REG_FILE_SB_BYPASS_EN): same-cycle writeback
// forwarding onto the read ports. When the macro is undefined, readers see
// the new value one cycle after the writeback edge.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rd_addr1/2            read addresses
//   rd_data1/2            read data (combinational)
//   rd_ready1/2           read data is final (no pending writer)
//   res_valid, res_addr   reservation request from issue
//   res_ready             reservation can be accepted this cycle
//   wb_en, wb_addr, wb_data   writeback
//   busy_any              some register has a pending writer
//   err_sticky            writeback seen to a register with no reservation
//   clr_err               synchronous clear of err_sticky
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_addr,
    output logic              res_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy_any,
    output logic              err_sticky,
    input  logic              clr_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [DEPTH-1:0]  busy_vec;

    logic res_acc;
    logic wb_hit;
    logic wb_orphan;
    logic err_reg;

    // Address 0 is always accepted so issue never stalls on it; it simply
    // has no effect on the scoreboard.
    assign res_ready = (res_addr == '0) || (cnt_q[res_addr] != CNT_MAX);
    assign res_acc   = res_valid && res_ready && (res_addr != '0);
    assign wb_hit    = wb_en && (wb_addr != '0);
    assign wb_orphan = wb_hit && (cnt_q[wb_addr] == '0);

    // ------------------------------------------------------------------
    // Register storage and per-register pending-write counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign data_q[gi]   = '0;
                assign cnt_q[gi]    = '0;
                assign busy_vec[gi] = 1'b0;
            end else begin : g_live
                logic [DATA_W-1:0] data_reg;
                logic [CNT_W-1:0]  cnt_reg;
                logic [CNT_W-1:0]  cnt_next;
                logic              inc;
                logic              dec;

                // Increment is already blocked at saturation by res_ready;
                // decrement is blocked at zero so an orphan writeback cannot
                // wrap the counter.
                assign inc = res_acc && (res_addr == ADDR_W'(gi));
                assign dec = wb_en && (wb_addr == ADDR_W'(gi)) && (cnt_reg != '0);

                always_comb begin
                    cnt_next = cnt_reg;
                    if (inc && !dec) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end else if (dec && !inc) begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= '0;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (wb_en && (wb_addr == ADDR_W'(gi))) begin
                            data_reg <= wb_data;
                        end
                    end
                end

                assign data_q[gi]   = data_reg;
                assign cnt_q[gi]    = cnt_reg;
                assign busy_vec[gi] = (cnt_reg != '0);
            end
        end
    endgenerate

    assign busy_any = |busy_vec;

    // ------------------------------------------------------------------
    // Error flag: a set in the same cycle as a clear takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (wb_orphan) begin
            err_reg <= 1'b1;
        end else if (clr_err) begin
            err_reg <= 1'b0;
        end
    end

    assign err_sticky = err_reg;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr_a  [2];
    logic [DATA_W-1:0] rd_data_a  [2];
    logic              rd_ready_a [2];

    assign rd_addr_a[0] = rd_addr1;
    assign rd_addr_a[1] = rd_addr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] data_next;
            logic              ready_next;

            always_comb begin
                data_next  = data_q[rd_addr_a[gi]];
                ready_next = (cnt_q[rd_addr_a[gi]] == '0);
`ifdef REG_FILE_SB_BYPASS_EN
                // Forward the writeback landing this cycle. It is final only
                // if it is the last outstanding writer and no new writer is
                // being reserved for the same register on this edge.
                if (wb_en && (wb_addr == rd_addr_a[gi]) && (rd_addr_a[gi] != '0)) begin
                    data_next = wb_data;
                    if ((cnt_q[rd_addr_a[gi]] == CNT_ONE) &&
                        !(res_acc && (res_addr == rd_addr_a[gi]))) begin
                        ready_next = 1'b1;
                    end
                end
`endif
            end

            assign rd_data_a[gi]  = data_next;
            assign rd_ready_a[gi] = ready_next;
        end
    endgenerate

    assign rd_data1  = rd_data_a[0];
    assign rd_data2  = rd_data_a[1];
    assign rd_ready1 = rd_ready_a[0];
    assign rd_ready2 = rd_ready_a[1];

endmodule
